lii_gearbox_wrapper: RTL and testbench

Parametrised LII-to-HLS-kernel adapter that connects one LII physical channel pair to one kernel stream pair. Phy and kernel widths may differ by an integer ratio: R phy beats assemble into one kernel word, and each kernel word splits back into R phy beats. A registered output FIFO decouples kernel back-pressure from the phy. The kernel clock enable is derived from FIFO occupancy rather than from combinational ready paths. It sits between the LII fabric port and each HLS layer kernel (conv/pool/fc) in the stream configuration.

---
 rtl/lii_pkg.sv | 27 ++
 rtl/lii_gearbox_wrapper_if.sv | 23 ++
 rtl/lii_sync_fifo.sv | 46 ++++
 rtl/lii_gearbox_wrapper.sv | 137 +++++++++++++
 tb/tb_lii_gearbox_wrapper.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lii_pkg.sv
// Shared definitions for the LII gearbox wrappers: ID width, sizing helpers
// and the routing-tag beat type.
package lii_pkg;

    localparam int LII_ID_W = 8;

    typedef logic [LII_ID_W-1:0] lii_id_t;

    typedef struct packed {
        lii_id_t src;
        lii_id_t dst;
    } lii_route_t;

    function automatic int lii_ratio(input int pw, input int dw);
        return dw / pw;
    endfunction

    function automatic int lii_cnt_w(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

    // One extra MSB distinguishes full from empty when the pointers wrap.
    function automatic int lii_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lii_gearbox_wrapper_if.sv
// Stream interfaces for the gearbox: LII phy channel (with routing tags) and
// plain AXI-Stream towards the HLS kernel.
interface lii_phy_if #(parameter int W = 64);
    import lii_pkg::*;

    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    lii_id_t      src;
    lii_id_t      dst;

    modport master (output tdata, tvalid, src, dst, input tready);
    modport slave  (input tdata, tvalid, src, dst, output tready);
endinterface

interface axis_if #(parameter int W = 128);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, tvalid, input tready);
    modport slave  (input tdata, tvalid, output tready);
endinterface

// File: rtl/lii_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers and a
// registered occupancy count.
module lii_sync_fifo
    import lii_pkg::*;
#(
    parameter int W     = 128,
    parameter int DEPTH = 4,
    localparam int PTR_W = lii_ptr_w(DEPTH)
) (
    input  logic             aclk,
    input  logic             arst,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic             empty,
    output logic             full,
    output logic [PTR_W-1:0] count
);
    localparam int AW = PTR_W - 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    always_ff @(posedge aclk) begin
        if (arst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
        end
    end

    // NOTE: storage is deliberately not reset; validity comes from the pointers alone.
    always_ff @(posedge aclk) begin
        if (push) mem[wptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;

endmodule

// File: rtl/lii_gearbox_wrapper.sv
// LII phy <-> HLS kernel gearbox: R phy beats per kernel word each way, output
// FIFO with occupancy-derived ce. Optional dst filtering under LII_DST_CHECK_EN.
module lii_gearbox_wrapper
    import lii_pkg::*;
#(
    parameter int      PW       = 64,
    parameter int      DW       = 128,
    parameter int      DEPTH    = 4,
    parameter int      CE_SLACK = 2,
    parameter lii_id_t SRC_ID   = '0,
    parameter lii_id_t DST_ID   = '0,
    parameter lii_id_t NODE_ID  = '0
) (
    input  logic              aclk,
    input  logic              arst,
    lii_phy_if.slave          lii_in_p0,
    lii_phy_if.master         lii_out_p0,
    axis_if.master            in_stream,
    axis_if.slave             out_stream,
    output logic              ce,
    output logic [15:0]       drop_cnt
);
    localparam int R     = lii_ratio(PW, DW);
    localparam int CNT_W = lii_cnt_w(R);
    localparam int PTR_W = lii_ptr_w(DEPTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(R - 1);
    localparam lii_route_t       ROUTE = '{src: SRC_ID, dst: DST_ID};

    // ---------------- input assembler ----------------
    logic [CNT_W-1:0] icnt;
    logic [DW-1:0]    acc;
    logic [DW-1:0]    oword;
    logic [DW-1:0]    merged;
    logic             ovalid;
    logic             in_fire;
    logic             keep;

    assign in_fire = lii_in_p0.tvalid && lii_in_p0.tready;

`ifdef LII_DST_CHECK_EN
    assign keep = (lii_in_p0.dst == NODE_ID);
`else
    assign keep = 1'b1;
`endif

    // NOTE: merged takes a full default from acc before the slice overwrite, so no latch.
    always_comb begin
        merged = acc;
        merged[icnt*PW +: PW] = lii_in_p0.tdata;
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            icnt   <= '0;
            ovalid <= 1'b0;
        end else begin
            if (in_fire && keep)
                icnt <= (icnt == LAST) ? '0 : icnt + CNT_W'(1);
            if (in_fire && keep && icnt == LAST)
                ovalid <= 1'b1;
            else if (in_stream.tready)
                ovalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (in_fire && keep) begin
            acc <= merged;
            if (icnt == LAST) oword <= merged;
        end
    end

    // The last beat only stalls while the finished word is still unclaimed.
    assign lii_in_p0.tready = !arst && ((icnt != LAST) || !ovalid || in_stream.tready);
    assign in_stream.tvalid = ovalid && !arst;
    assign in_stream.tdata  = oword;

`ifdef LII_DST_CHECK_EN
    always_ff @(posedge aclk) begin
        if (arst)
            drop_cnt <= '0;
        else if (in_fire && !keep && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end
`else
    assign drop_cnt = '0;
`endif

    logic unused_tags;
    assign unused_tags = ^{lii_in_p0.src, lii_in_p0.dst, NODE_ID};

    // ---------------- output FIFO + disassembler ----------------
    logic             push;
    logic             pop;
    logic             out_fire;
    logic             fifo_empty;
    logic             fifo_full;
    logic [DW-1:0]    head;
    logic [PTR_W-1:0] count;
    logic [CNT_W-1:0] ocnt;

    assign out_stream.tready = !arst && !fifo_full;
    assign push              = out_stream.tvalid && out_stream.tready;

    lii_sync_fifo #(
        .W     (DW),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .aclk  (aclk),
        .arst  (arst),
        .push  (push),
        .din   (out_stream.tdata),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (count)
    );

    assign lii_out_p0.tvalid = !arst && !fifo_empty;
    assign lii_out_p0.tdata  = head[ocnt*PW +: PW];
    assign {lii_out_p0.src, lii_out_p0.dst} = ROUTE;

    assign out_fire = lii_out_p0.tvalid && lii_out_p0.tready;
    assign pop      = out_fire && (ocnt == LAST);

    always_ff @(posedge aclk) begin
        if (arst)
            ocnt <= '0;
        else if (out_fire)
            ocnt <= (ocnt == LAST) ? '0 : ocnt + CNT_W'(1);
    end

    // Registered count only: ce has no path from any tready.
    assign ce = !arst && ((DEPTH - int'(count)) >= CE_SLACK);

endmodule

// File: tb/tb_lii_gearbox_wrapper.sv
// Self-checking bench for lii_gearbox_wrapper: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_lii_gearbox_wrapper;

    localparam int PW       = 64;
    localparam int DW       = 128;
    localparam int R        = DW / PW;
    localparam int DEPTH    = 4;
    localparam int CE_SLACK = 2;
    localparam logic [7:0] SRC_ID  = 8'hA5;
    localparam logic [7:0] DST_ID  = 8'h3C;
    localparam logic [7:0] NODE_ID = 8'h05;
`ifdef LII_DST_CHECK_EN
    localparam bit DST_CHECK = 1'b1;
`else
    localparam bit DST_CHECK = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        arst;
    logic        ce;
    logic [15:0] drop_cnt;

    always #5 aclk = ~aclk;

    lii_phy_if #(.W(PW)) lii_in ();
    lii_phy_if #(.W(PW)) lii_out ();
    axis_if    #(.W(DW)) in_stream ();
    axis_if    #(.W(DW)) out_stream ();

    lii_gearbox_wrapper #(
        .PW       (PW),
        .DW       (DW),
        .DEPTH    (DEPTH),
        .CE_SLACK (CE_SLACK),
        .SRC_ID   (SRC_ID),
        .DST_ID   (DST_ID),
        .NODE_ID  (NODE_ID)
    ) dut (
        .aclk       (aclk),
        .arst       (arst),
        .lii_in_p0  (lii_in),
        .lii_out_p0 (lii_out),
        .in_stream  (in_stream),
        .out_stream (out_stream),
        .ce         (ce),
        .drop_cnt   (drop_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: beats collected towards the next word, finished words
    // awaiting the kernel, and kernel words awaiting transmission on the phy.
    logic [PW-1:0] ibuf [$];
    logic [DW-1:0] pend [$];
    logic [DW-1:0] kq   [$];
    int  kidx  = 0;
    int  drops = 0;
    bit  in_hs, kin_hs, kout_hs, pout_hs;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs already driven; compares, advances the
    // model by whatever transfers happen at the next posedge, ends at the next negedge.
    task automatic step();
        logic [DW-1:0] w;
        logic [PW-1:0] exp_beat;
        #1;
        if (arst) begin
            check("rst_in_tready",  lii_in.tready,     1'b0);
            check("rst_k_tvalid",   in_stream.tvalid,  1'b0);
            check("rst_kout_tready", out_stream.tready, 1'b0);
            check("rst_phy_tvalid", lii_out.tvalid,    1'b0);
            check("rst_ce",         ce,                1'b0);
            ibuf.delete(); pend.delete(); kq.delete();
            kidx = 0; drops = 0;
            in_hs = 0; kin_hs = 0; kout_hs = 0; pout_hs = 0;
        end else begin
            check("in_tready", lii_in.tready,
                  !((ibuf.size() == R - 1) && (pend.size() != 0) && !in_stream.tready));
            check("k_tvalid", in_stream.tvalid, pend.size() != 0);
            if (pend.size() != 0) check_data("k_tdata", in_stream.tdata, pend[0]);
            check("kout_tready", out_stream.tready, kq.size() < DEPTH);
            check("ce", ce, (DEPTH - kq.size()) >= CE_SLACK);
            check("phy_tvalid", lii_out.tvalid, kq.size() != 0);
            if (kq.size() != 0) begin
                w = kq[0];
                exp_beat = w[kidx*PW +: PW];
                check_data("phy_tdata", DW'(lii_out.tdata), DW'(exp_beat));
            end
            check_data("phy_src", DW'(lii_out.src), DW'(SRC_ID));
            check_data("phy_dst", DW'(lii_out.dst), DW'(DST_ID));
            check_data("drop_cnt", DW'(drop_cnt), DW'(drops));

            in_hs   = lii_in.tvalid     && lii_in.tready;
            kin_hs  = in_stream.tvalid  && in_stream.tready;
            kout_hs = out_stream.tvalid && out_stream.tready;
            pout_hs = lii_out.tvalid    && lii_out.tready;

            if (kin_hs && pend.size() != 0) void'(pend.pop_front());
            if (in_hs) begin
                if (DST_CHECK && lii_in.dst != NODE_ID) begin
                    if (drops < 65535) drops++;
                end else begin
                    ibuf.push_back(lii_in.tdata);
                    if (ibuf.size() == R) begin
                        w = '0;
                        for (int k = 0; k < R; k++) w[k*PW +: PW] = ibuf[k];
                        pend.push_back(w);
                        ibuf.delete();
                    end
                end
            end
            if (pout_hs && kq.size() != 0) begin
                kidx++;
                if (kidx == R) begin
                    void'(kq.pop_front());
                    kidx = 0;
                end
            end
            if (kout_hs) kq.push_back(out_stream.tdata);
        end
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic send_beat(input logic [PW-1:0] d, input logic [7:0] dst);
        lii_in.tvalid = 1'b1;
        lii_in.tdata  = d;
        lii_in.dst    = dst;
        lii_in.src    = 8'($urandom);
        for (int i = 0; i < 40; i++) begin
            step();
            if (in_hs) break;
        end
        check("send_beat_accepted", in_hs, 1'b1);
        lii_in.tvalid = 1'b0;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        out_stream.tvalid = 1'b1;
        out_stream.tdata  = d;
        for (int i = 0; i < 40; i++) begin
            step();
            if (kout_hs) break;
        end
        check("push_word_accepted", kout_hs, 1'b1);
        out_stream.tvalid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [PW-1:0] b1, b2, b3, b4;
        arst = 1'b1;
        lii_in.tvalid = 0; lii_in.tdata = '0; lii_in.src = '0; lii_in.dst = NODE_ID;
        out_stream.tvalid = 0; out_stream.tdata = '0;
        in_stream.tready = 0; lii_out.tready = 0;
        @(negedge aclk);
        repeat (3) step();
        arst = 1'b0;

        #1;
        check("post_rst_in_tready",   lii_in.tready,     1'b1);
        check("post_rst_kout_tready", out_stream.tready, 1'b1);
        check("post_rst_ce",          ce,                1'b1);

        // Two beats assemble low-first into one kernel word.
        in_stream.tready = 1'b1;
        send_beat(64'h1111_1111_1111_1111, NODE_ID);
        send_beat(64'h2222_2222_2222_2222, NODE_ID);
        #1;
        check("asm_valid", in_stream.tvalid, 1'b1);
        check_data("asm_word", in_stream.tdata,
                   128'h2222_2222_2222_2222_1111_1111_1111_1111);
        step();

        // Kernel word {A,B} leaves as B then A.
        lii_out.tready = 1'b1;
        push_word({64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB});
        #1;
        check("dis_valid0", lii_out.tvalid, 1'b1);
        check_data("dis_beat0", DW'(lii_out.tdata), DW'(64'hBBBB_BBBB_BBBB_BBBB));
        step();
        #1;
        check_data("dis_beat1", DW'(lii_out.tdata), DW'(64'hAAAA_AAAA_AAAA_AAAA));
        step();
        #1;
        check("dis_done", lii_out.tvalid, 1'b0);

        // ce and FIFO back-pressure.
        lii_out.tready = 1'b0;
        repeat (3) push_word({$urandom, $urandom, $urandom, $urandom});
        #1;
        check("ce_low_at3", ce, 1'b0);
        check("kout_rdy_at3", out_stream.tready, 1'b1);
        lii_out.tready = 1'b1;
        step();
        step();
        #1;
        check("ce_back_after_pop", ce, 1'b1);
        lii_out.tready = 1'b0;
        repeat (2) push_word({$urandom, $urandom, $urandom, $urandom});
        #1;
        check("kout_rdy_at4", out_stream.tready, 1'b0);
        lii_out.tready = 1'b1;
        repeat (10) step();

        // Pending word blocks only the last beat of the next word.
        in_stream.tready = 1'b0;
        send_beat({$urandom, $urandom}, NODE_ID);
        send_beat({$urandom, $urandom}, NODE_ID);
        send_beat({$urandom, $urandom}, NODE_ID);
        lii_in.tvalid = 1'b1;
        lii_in.tdata  = {$urandom, $urandom};
        lii_in.dst    = NODE_ID;
        repeat (3) begin
            #1;
            check("stall_tready", lii_in.tready, 1'b0);
            step();
        end
        in_stream.tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (in_hs) break;
        end
        check("stall_released", in_hs, 1'b1);
        lii_in.tvalid = 1'b0;
        repeat (4) step();

        // Reset mid-word discards the stale beat.
        send_beat(64'hDEAD_DEAD_DEAD_DEAD, NODE_ID);
        arst = 1'b1;
        repeat (2) step();
        arst = 1'b0;
        b1 = {$urandom, $urandom};
        b2 = {$urandom, $urandom};
        send_beat(b1, NODE_ID);
        send_beat(b2, NODE_ID);
        #1;
        check("rst_fresh_valid", in_stream.tvalid, 1'b1);
        check_data("rst_fresh_word", in_stream.tdata, {b2, b1});
        step();

        // Destination filtering (beats for other nodes are dropped only when enabled).
        b3 = {$urandom, $urandom};
        b4 = {$urandom, $urandom};
        b1 = {$urandom, $urandom};
        send_beat(b1, NODE_ID);
        send_beat(b3, 8'h07);
        send_beat(b4, NODE_ID);
`ifdef LII_DST_CHECK_EN
        #1;
        check("dst_word_valid", in_stream.tvalid, 1'b1);
        check_data("dst_word", in_stream.tdata, {b4, b1});
        check_data("dst_drop_cnt", DW'(drop_cnt), DW'(16'd1));
`else
        #1;
        check_data("dst_drop_cnt_tied", DW'(drop_cnt), DW'(16'd0));
`endif
        step();

        // Randomized traffic with AXI-Stream valid/data stability.
        in_hs = 0; kout_hs = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!lii_in.tvalid || in_hs) begin
                lii_in.tvalid = ($urandom_range(0, 3) != 0);
                lii_in.tdata  = {$urandom, $urandom};
                lii_in.dst    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : NODE_ID;
                lii_in.src    = 8'($urandom);
            end
            if (!out_stream.tvalid || kout_hs) begin
                out_stream.tvalid = ($urandom_range(0, 2) != 0);
                out_stream.tdata  = {$urandom, $urandom, $urandom, $urandom};
            end
            in_stream.tready = ($urandom_range(0, 3) != 0);
            lii_out.tready   = ($urandom_range(0, 2) != 0);
            step();
        end

        // Drain.
        lii_in.tvalid = 0; out_stream.tvalid = 0;
        in_stream.tready = 1; lii_out.tready = 1;
        repeat (20) step();
        #1;
        check("drain_k_tvalid", in_stream.tvalid, 1'b0);
        check("drain_phy_tvalid", lii_out.tvalid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
